// File: rtl/gpu_pkg.sv
// gpu_pkg: shared definitions for the GPU stream blocks.
//   AXIS_DATA_WIDTH     - stream / memory word width (32 only)
//   READBACK_FIFO_DEPTH - entries in the readback skid buffer
//   rb_state_t          - readback FSM state encoding
// The CSUM state exists only when GPU_READBACK_CHECKSUM_EN is defined.
package gpu_pkg;

  localparam int AXIS_DATA_WIDTH     = 32;
  localparam int READBACK_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    RB_IDLE   = 2'd0,
    RB_STREAM = 2'd1,
`ifdef GPU_READBACK_CHECKSUM_EN
    RB_CSUM   = 2'd2,
`endif
    RB_FINISH = 2'd3
  } rb_state_t;

endpackage

// File: rtl/axis_skid_fifo.sv
// axis_skid_fifo: 2-entry data buffer sitting between the memory read
// return and the AXI-Stream output.
//   clk, rst        - clock, asynchronous active-high reset
//   push, push_data - write one word (caller guarantees not full)
//   pop             - drop the head word (caller guarantees not empty)
//   head_data       - oldest stored word
//   head_valid      - at least one word is stored
//   occupancy       - number of stored words (0..2)
module axis_skid_fifo
  import gpu_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] entry [READBACK_FIFO_DEPTH];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < READBACK_FIFO_DEPTH; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] data_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= push_data;
        end
      end
      assign entry[gi] = data_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data  = entry[rd_ptr_reg];
  assign head_valid = (count_reg != 2'd0);
  assign occupancy  = count_reg;

endmodule

// File: rtl/gpu_axis_readback.sv
// gpu_axis_readback: AXI-Stream master that streams a contiguous block of
// data-memory words to the host.
//   axis_clk, reset              - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          - command handshake
//   cmd_base_addr, cmd_len       - first word address, word count (0..2^ADDR_WIDTH)
//   mem_rd_en, mem_addr          - synchronous read port (data 1 cycle later)
//   mem_rd_data                  - read return data
//   axis_tdata/tkeep/tlast/tvalid/tready - outbound stream
//   busy                         - command accepted, transfer not yet done
//   done                         - one-cycle completion pulse
// Optional feature: GPU_READBACK_CHECKSUM_EN appends a beat carrying the
// modulo-2^32 sum of all data words; that beat alone carries tlast.
module gpu_axis_readback
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH
) (
  input  logic                  axis_clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] axis_tdata,
  output logic                  axis_tkeep,
  output logic                  axis_tlast,
  output logic                  axis_tvalid,
  input  logic                  axis_tready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] ONE_BEAT = {{ADDR_WIDTH{1'b0}}, 1'b1};

  rb_state_t             state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH:0]   reads_left_reg;
  logic [ADDR_WIDTH:0]   beats_left_reg;
  logic                  inflight_reg;

  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_valid;
  logic [1:0]            occupancy;
  logic                  fifo_pop;
  logic [2:0]            credit;
  logic                  issue;

  // A word leaving the buffer this cycle frees its slot for a new read,
  // which keeps one beat per cycle while never holding more than two words.
  assign fifo_pop = (state_reg == RB_STREAM) && head_valid && axis_tready;
  assign credit   = {2'b00, inflight_reg} + {1'b0, occupancy} - {2'b00, fifo_pop};
  assign issue    = (state_reg == RB_STREAM) && (reads_left_reg != '0) && (credit < 3'd2);

  axis_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk       (axis_clk),
    .rst       (reset),
    .push      (inflight_reg),
    .push_data (mem_rd_data),
    .pop       (fifo_pop),
    .head_data (head_data),
    .head_valid(head_valid),
    .occupancy (occupancy)
  );

`ifdef GPU_READBACK_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_reg;
`endif

  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset) begin
      state_reg      <= RB_IDLE;
      addr_reg       <= '0;
      reads_left_reg <= '0;
      beats_left_reg <= '0;
      inflight_reg   <= 1'b0;
`ifdef GPU_READBACK_CHECKSUM_EN
      sum_reg        <= '0;
`endif
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        addr_reg       <= addr_reg + 1'b1;
        reads_left_reg <= reads_left_reg - 1'b1;
      end
      case (state_reg)
        RB_IDLE: begin
          if (cmd_valid) begin
            addr_reg       <= cmd_base_addr;
            reads_left_reg <= cmd_len;
            beats_left_reg <= cmd_len;
`ifdef GPU_READBACK_CHECKSUM_EN
            sum_reg        <= '0;
`endif
            state_reg      <= (cmd_len == '0) ? RB_FINISH : RB_STREAM;
          end
        end
        RB_STREAM: begin
          if (fifo_pop) begin
            beats_left_reg <= beats_left_reg - 1'b1;
`ifdef GPU_READBACK_CHECKSUM_EN
            sum_reg        <= sum_reg + head_data;
            if (beats_left_reg == ONE_BEAT) state_reg <= RB_CSUM;
`else
            if (beats_left_reg == ONE_BEAT) state_reg <= RB_FINISH;
`endif
          end
        end
`ifdef GPU_READBACK_CHECKSUM_EN
        RB_CSUM: begin
          if (axis_tready) state_reg <= RB_FINISH;
        end
`endif
        RB_FINISH: state_reg <= RB_IDLE;
        default:   state_reg <= RB_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_reg == RB_IDLE);
  assign done      = (state_reg == RB_FINISH);
  assign mem_rd_en = issue;
  assign mem_addr  = addr_reg;

`ifdef GPU_READBACK_CHECKSUM_EN
  assign busy        = (state_reg == RB_STREAM) || (state_reg == RB_CSUM);
  assign axis_tvalid = head_valid || (state_reg == RB_CSUM);
  assign axis_tdata  = (state_reg == RB_CSUM) ? sum_reg :
                       (head_valid ? head_data : '0);
  assign axis_tlast  = (state_reg == RB_CSUM);
`else
  assign busy        = (state_reg == RB_STREAM);
  assign axis_tvalid = head_valid;
  assign axis_tdata  = head_valid ? head_data : '0;
  assign axis_tlast  = head_valid && (beats_left_reg == ONE_BEAT);
`endif
  assign axis_tkeep  = axis_tvalid;

endmodule

// File: tb/tb_gpu_axis_readback.sv
// tb_gpu_axis_readback: table-driven and randomized check of the readback
// stream against a queue-based model of the memory block being sent.
module tb_gpu_axis_readback;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] axis_tdata;
  logic          axis_tkeep;
  logic          axis_tlast;
  logic          axis_tvalid;
  logic          axis_tready = 1'b0;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gpu_axis_readback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .axis_clk     (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base_addr(cmd_base_addr),
    .cmd_len      (cmd_len),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .axis_tdata   (axis_tdata),
    .axis_tkeep   (axis_tkeep),
    .axis_tlast   (axis_tlast),
    .axis_tvalid  (axis_tvalid),
    .axis_tready  (axis_tready),
    .busy         (busy),
    .done         (done)
  );

  // synchronous-read data memory
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    chk({tag, " outs"}, {mem_rd_en, axis_tkeep, axis_tlast, axis_tvalid, busy, done}, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " tdata"}, axis_tdata, 0);
  endtask

  function automatic logic pick_ready(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return ($urandom_range(0, 3) == 0);
    endcase
  endfunction

  // mode: 0 ready always, 1 random 50%, 2 mostly stalled.
  // timing: also check cycle-exact latency / no-bubble behaviour.
  // reset_after: >0 asserts reset once that many beats have completed.
  task automatic run_cmd(input logic [AW-1:0] base, input int len, input int mode,
                         input bit timing, input int reset_after,
                         output logic [31:0] first_w, output logic [31:0] last_data_w,
                         output int data_beats, output logic [31:0] tail_w,
                         output int total_beats);
    logic [31:0] exp_q[$];
    logic [31:0] sum;
    logic [31:0] prev_data;
    logic        prev_last;
    bit          prev_stall;
    bit          done_seen;
    int          idx, cyc, last_hs, reads, budget;
    sum = 0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(mem[(int'(base) + i) % DEPTH]);
      sum += mem[(int'(base) + i) % DEPTH];
    end
`ifdef GPU_READBACK_CHECKSUM_EN
    if (len > 0) exp_q.push_back(sum);
`endif
    first_w = 0; last_data_w = 0; tail_w = 0; data_beats = 0; total_beats = 0;
    idx = 0; reads = 0; last_hs = -1; done_seen = 0; prev_stall = 0;
    prev_data = 0; prev_last = 0;
    budget = 10 * len + 50;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_base_addr = base; cmd_len = (AW+1)'(len);
    #1;
    chk("cmd_ready idle", cmd_ready, 1);
    for (cyc = 0; cyc < budget && !done_seen; cyc++) begin
      @(negedge clk);
      // junk commands while busy must be ignored
      cmd_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_len = (AW+1)'($urandom_range(0, 8));
      axis_tready = pick_ready(mode);
      #1;
      chk("tkeep==tvalid", axis_tkeep, axis_tvalid);
      if (prev_stall) chk("stall hold", {axis_tvalid, axis_tlast, axis_tdata}, {1'b1, prev_last, prev_data});
      if (mem_rd_en) begin
        chk("mem_addr", mem_addr, (int'(base) + reads) % DEPTH);
        reads++;
      end
      if (axis_tvalid && axis_tready) begin
        if (idx < exp_q.size()) begin
          chk("beat data", axis_tdata, exp_q[idx]);
          chk("beat tlast", axis_tlast, (idx == exp_q.size() - 1));
          if (timing) chk("beat cycle", cyc, 2 + idx);
          if (idx == 0) first_w = axis_tdata;
          if (idx == len - 1) last_data_w = axis_tdata;
          if (idx < len) data_beats++;
          tail_w = axis_tdata;
        end else begin
          chk("extra beat", idx, exp_q.size());
        end
        idx++;
        total_beats = idx;
        if (idx == exp_q.size()) last_hs = cyc;
      end
      chk("reads ahead", ((reads - data_beats) <= 2), 1);
      if (done) begin
        done_seen = 1;
        chk("done cycle", cyc, last_hs + 1);
        chk("done busy/ready", {busy, cmd_ready}, 2'b00);
        chk("beats at done", idx, exp_q.size());
        chk("reads at done", reads, len);
      end else begin
        chk("busy while active", {busy, cmd_ready}, 2'b10);
      end
      prev_stall = axis_tvalid && !axis_tready;
      prev_data  = axis_tdata;
      prev_last  = axis_tlast;
      if (reset_after > 0 && idx == reset_after && axis_tvalid && axis_tready) begin
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_values("mid reset");
        cmd_valid = 1'b0;
        return;
      end
    end
    if (!done_seen) chk("done timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("cmd_ready after done", cmd_ready, 1);
    $display("cmd base=%03h len=%0d mode=%0d beats=%0d reads=%0d", base, len, mode, total_beats, reads);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            mode;
    bit            timing;
    logic [31:0]   exp_first;
    logic [31:0]   exp_last;
    int            exp_beats;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    logic [31:0] fw, lw, tw;
    int          nb, tb_total;
    bit          done_in_reset;

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + i;

    vecs[0] = '{12'h010, 4,    0, 1, 32'hA000_0010, 32'hA000_0013, 4};
    vecs[1] = '{12'h020, 8,    1, 0, 32'hA000_0020, 32'hA000_0027, 8};
    vecs[2] = '{12'hFFE, 4,    0, 1, 32'hA000_0FFE, 32'hA000_0001, 4};
    vecs[3] = '{12'h000, 0,    0, 1, 32'h0,         32'h0,         0};
    vecs[4] = '{12'h123, 4096, 0, 1, 32'hA000_0123, 32'hA000_0122, 4096};
    vecs[5] = '{12'h300, 5,    2, 0, 32'hA000_0300, 32'hA000_0304, 5};

    // reset values, while held and after release
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset held");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_values("after reset");

    foreach (vecs[k]) begin
      run_cmd(vecs[k].base, vecs[k].len, vecs[k].mode, vecs[k].timing, 0, fw, lw, nb, tw, tb_total);
      chk($sformatf("vec%0d first", k), fw, vecs[k].exp_first);
      chk($sformatf("vec%0d last", k), lw, vecs[k].exp_last);
      chk($sformatf("vec%0d beats", k), nb, vecs[k].exp_beats);
    end

    // reset after the 3rd beat of a 16-word transfer
    run_cmd(12'h100, 16, 0, 1, 3, fw, lw, nb, tw, tb_total);
    done_in_reset = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_in_reset = 1;
    end
    chk("no done in reset", done_in_reset, 0);
    reset = 1'b0;
    #1;
    chk_reset_values("after mid reset");
    run_cmd(12'h050, 2, 0, 1, 0, fw, lw, nb, tw, tb_total);
    chk("post-reset first", fw, 32'hA000_0050);
    chk("post-reset last", lw, 32'hA000_0051);

    // checksum wrap case
    mem[12'h040] = 32'hFFFF_FFFF;
    mem[12'h041] = 32'h0000_0002;
    run_cmd(12'h040, 2, 0, 1, 0, fw, lw, nb, tw, tb_total);
`ifdef GPU_READBACK_CHECKSUM_EN
    chk("csum tail", tw, 32'h0000_0001);
    chk("csum beats", tb_total, 3);
`else
    chk("plain tail", tw, 32'h0000_0002);
    chk("plain beats", tb_total, 2);
`endif

    // randomized memory content and commands
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int r = 0; r < 12; r++) begin
      run_cmd(AW'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 40), $urandom_range(0, 2),
              0, 0, fw, lw, nb, tw, tb_total);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpu_axis_readback.md
# gpu_axis_readback

AXI-Stream master that reads a contiguous block of words from the GPU data memory and streams them to the host, the outbound counterpart of the host-to-GPU AXI-Stream data path. A single command supplies a base address and a word count. The block issues synchronous memory reads, buffers returned data so it fully honours `axis_tready` backpressure, and marks the final beat with `axis_tlast`. It lives in the `axis_clk` domain beside the inbound stream port inside the GPU top level.

## Interface
- `ADDR_WIDTH`, default 12: word-address width of the data memory read port.
- `DATA_WIDTH`, default 32: stream and memory word width. Only 32 is supported.
- `axis_clk` in 1: the single clock for all logic.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: a command is present.
- `cmd_ready` out 1: the block is idle and can accept a command.
- `cmd_base_addr` in ADDR_WIDTH: word address of the first word.
- `cmd_len` in ADDR_WIDTH+1: number of words to stream, from 0 to 2^ADDR_WIDTH.
- `mem_rd_en` out 1: read strobe to the data memory.
- `mem_addr` out ADDR_WIDTH: read address.
- `mem_rd_data` in DATA_WIDTH: read data, valid exactly 1 cycle after `mem_rd_en`.
- `axis_tdata` out DATA_WIDTH: stream data.
- `axis_tkeep` out 1: driven 1 while `axis_tvalid` is high, otherwise 0.
- `axis_tlast` out 1: marks the final beat of a transfer.
- `axis_tvalid` out 1: stream valid.
- `axis_tready` in 1: host ready.
- `busy` out 1: high from command acceptance until `done` is asserted.
- `done` out 1: one-cycle pulse when a transfer completes.

## Operation
- **FSM states:** IDLE, STREAM, CSUM (present only under the macro), FINISH.
- **IDLE:**
  - `cmd_ready`=1.
  - A handshake (`cmd_valid`&&`cmd_ready`) latches the base address and length and sets `busy`.
  - If `cmd_len`=0, go to FINISH. Otherwise go to STREAM.
- **STREAM, read issue:**
  - A read is issued when words remain and (reads in flight + buffer occupancy) < 2.
  - `mem_addr` increments by 1 per issued read and wraps modulo 2^ADDR_WIDTH.
- **STREAM, buffering:** returning data is written into a 2-entry FIFO. The head of the FIFO drives `axis_tdata` and `axis_tvalid`.
- **Beat counting:**
  - The beat counter decrements on each handshake (`axis_tvalid`&&`axis_tready`).
  - `axis_tlast`=1 on the beat where the counter equals 1, unless CSUM is compiled in.
  - After the last data handshake, go to CSUM (macro) or FINISH.
- **FINISH:** pulse `done`=1 and clear `busy` in the same cycle, then return to IDLE.
- **Stream rules:**
  - Once `axis_tvalid` is high, it and `axis_tdata`/`axis_tlast` hold stable until the handshake.
  - The block never drops or duplicates a word.
- **Length arithmetic:**
  - `cmd_len`=2^ADDR_WIDTH reads the whole memory once, wrapping back to the base address.
  - The counters are ADDR_WIDTH+1 bits wide.
- **`cmd_valid` while busy:** ignored, and `cmd_ready` stays 0.
- **Reset at any point:**
  - The FSM goes to IDLE and the FIFO is emptied.
  - Any in-flight read return is discarded.
  - No `done` pulse is generated.

## Timing
- **Reset values:** `cmd_ready`=1. `mem_rd_en`, `mem_addr`, `axis_tdata`, `axis_tkeep`, `axis_tlast`, `axis_tvalid`, `busy`, `done` are all 0.
- **Command accepted at edge E0:**
  - `busy`=1 and `cmd_ready`=0 after E0.
  - First `mem_rd_en` is high in the cycle following E0.
  - First `axis_tvalid` rises after E2, giving 2 cycles from acceptance to the first beat.
- **Throughput:** with `axis_tready` held high, one beat per cycle with no bubbles.
- **Backpressure:**
  - With `axis_tready` low, at most 2 words are read ahead and then `mem_rd_en` stays low.
  - Streaming resumes in the cycle `axis_tready` rises.
- **`done` timing:** `done` is asserted one cycle after the final (`axis_tlast`) handshake. `cmd_ready` returns 1 in the cycle after `done`.
- **Zero-length command:** `done` is asserted one cycle after acceptance, with no beats and no reads.

## Configuration
- **`GPU_READBACK_CHECKSUM_EN` defined:**
  - A 32-bit modulo-2^32 sum of every data word handed to the stream is accumulated.
  - After the last data beat, CSUM emits one extra beat carrying the sum, with `axis_tlast`=1 on that beat only.
  - A zero-length command still emits no beats.
- **`GPU_READBACK_CHECKSUM_EN` undefined:**
  - No accumulator and no CSUM state.
  - `axis_tlast` is on the last data word.

## Structure
- **Shared package `gpu_pkg`:** readback FSM state enum typedef, `AXIS_DATA_WIDTH`=32, and the FIFO depth constant 2.
- **Sub-module `axis_skid_fifo`:**
  - 2-entry data+valid buffer with push, pop and occupancy outputs.
  - It is the only natural split. Issue logic, counters, FSM and checksum stay in `gpu_axis_readback`.

## Test plan
- **Basic transfer:**
  - Memory[i]=0xA000_0000+i, base=0x010, len=4, `axis_tready`=1.
  - Expect beats 0xA000_0010..0xA000_0013 on consecutive cycles, first beat 2 cycles after acceptance, `tlast` on the 4th, `done` 1 cycle later.
- **Backpressure:**
  - len=8, `axis_tready` toggling 1-0-0-1 pseudo-randomly.
  - Expect all 8 words in order, no loss or duplication, at most 2 reads ahead while stalled, data stable while stalled.
- **Address wrap:** base=0xFFE, len=4. Expect addresses 0xFFE, 0xFFF, 0x000, 0x001. Full-memory len=4096 yields exactly 4096 beats.
- **Zero length:** len=0. Expect no `mem_rd_en`, no `tvalid`, and `done` 1 cycle after acceptance.
- **Reset mid-transfer:**
  - Assert `reset` after the 3rd beat of len=16.
  - Expect all outputs at reset values immediately with no `done`. A new len=2 command then streams correctly.
- **Checksum (`GPU_READBACK_CHECKSUM_EN`):** words 0xFFFF_FFFF, 0x0000_0002. Expect a third beat of 0x0000_0001 with `tlast`=1, and data beats with `tlast`=0.
